sndcomm_mailbox: RTL and testbench
==================================

// Module: sndcomm_mailbox
// PURPOSE
//  Parametrised successor to the Taito nibble-wide sound-communication chip.
//  Two CPU bus ports, master (main CPU) and slave (sound CPU), exchange NUM_SLOTS data slots each way through a paged register file.
//  Adds configurable width and depth, a status page and a sound-CPU reset control page.
//  Sits between the main CPU decode and the sound CPU; drives the sound-CPU NMI and reset.
// PARAMETERS
//  DATA_W     4  bus/slot width in bits; must be >= PAGE_W
//  NUM_SLOTS  4  slots per direction (m2s and s2m)
//  PAGE_W     4  page pointer width; NUM_SLOTS+3 < 2**PAGE_W
// PORTS
//  CLK    in  1       single system clock; all state on rising edge
//  nIC    in  1       asynchronous active-low reset
//  nMCS   in  1       master chip select, active low
//  nMRD   in  1       master read strobe, active low
//  nMWR   in  1       master write strobe, active low
//  MA0    in  1       master address: 0=page reg, 1=data
//  MD_I   in  DATA_W  master write data
//  MD_O   out DATA_W  master read data
//  MD_OE  out 1       master drive enable (=~nMCS&~nMRD)
//  nSCS, nSRD, nSWR, SA0, SD_I, SD_O, SD_OE   slave equivalents of the above
//  nNMI   out 1       sound-CPU NMI, active low, level
//  nROUT  out 1       sound-CPU reset, active low
// BEHAVIOUR
//  Reset values: all slots 0, both page pointers 0, ready flags 0, nmi_en 0, rout 1.
//   Outputs: nNMI=1, nROUT=0, MD_O/SD_O=0, MD_OE/SD_OE=0.
//  Strobes are sampled each CLK. A "commit" is the cycle where the strobe is sampled high and was low the previous cycle.
//   CS and A0 are taken from that previous sample. Commit latency 1 cycle after strobe deassert.
//  Write, A0=0: page pointer <= D[PAGE_W-1:0]. No other effect.
//  Write/read, A0=1: page p selects the target:
//   p<NUM_SLOTS         own outgoing slot p (write) / incoming slot p (read).
//                       Pointer += 1 on commit, wrapping NUM_SLOTS-1 -> 0.
//   p==NUM_SLOTS        status (read only): bit0 = incoming ready, bit1 = outgoing still pending, rest 0.
//   p==NUM_SLOTS+1      slave write: nmi_en<=0.
//   p==NUM_SLOTS+2      slave write: nmi_en<=1.
//   p==NUM_SLOTS+3      master write: rout<=D[0].
//   other               writes ignored, reads return 0, no pointer change.
//   Pointer does not move on non-slot pages.
//  Read data is combinational from the current pointer while OE=1. Side effects happen only on the read commit.
//  Ready flags: a write commit to slot NUM_SLOTS-1 sets that direction's flag.
//   A read commit of slot NUM_SLOTS-1 by the receiving side clears it.
//   If set and clear happen in the same cycle, set wins.
//  nNMI = ~(nmi_en & m2s_ready). nROUT = ~rout.
//  Simultaneous master and slave commits in one cycle are both honoured; the ports share no state except the flags.
//  nIC asserted mid-access: state resets immediately. A strobe already low at release does not commit until it rises.
// CONFIGURATION
//  SNDCOMM_SYNC_EN defined: a 2-flop synchroniser sits on each port's CS/RD/WR/A0 and data input.
//   Commit latency becomes 3 cycles after strobe deassert. OE remains combinational.
//  Undefined: inputs are sampled directly and the ports are assumed synchronous to CLK. Latency 1 cycle.
// STRUCTURE
//  Package sndcomm_pkg holds:
//   page-offset constants (STATUS_OFS=0, NMI_DIS_OFS=1, NMI_EN_OFS=2, ROUT_OFS=3, each added to NUM_SLOTS);
//   status bit indices;
//   typedef page_kind_e {PK_SLOT, PK_STATUS, PK_CTRL, PK_NONE}.
//  Sub-module sndcomm_port, instantiated twice, contains:
//   optional synchroniser, edge detect, page pointer with wrap, page decode.
//   It emits one-cycle wr_commit/rd_commit pulses plus slot index.
//  Top level holds both slot arrays, the flags, nmi_en and rout.
// TESTING
//  1 Reset release -> nNMI=1, nROUT=0, MD_OE=SD_OE=0. Slave status read returns 0.
//  2 Master: page 0, write 1,2,3,4 -> pointer wraps to 0.
//    Slave: page 0, reads -> 1,2,3,4. Status bit0 goes 1 then 0 after the 4th read commit.
//  3 Slave: page NUM_SLOTS+2 write -> nmi_en=1.
//    Master writes slot 3 -> nNMI=0 one cycle after commit. Slave reads slot 3 -> nNMI=1.
//  4 Master: page NUM_SLOTS+3, write 0 -> nROUT=1. Write 1 -> nROUT=0.
//    The same write from the slave has no effect.
//  5 Master write commit to slot 3 and slave read commit of slot 3 in the same cycle -> m2s_ready=1.
//  6 nIC pulsed low mid-write with nMWR held low -> slots stay 0.
//    No commit until nMWR rises after reset. With SNDCOMM_SYNC_EN, latency is 3 cycles.

Source files
------------

// File: rtl/sndcomm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sndcomm_pkg
//  Description : Shared page offsets, status bit positions and page decode
//                for the sound-communication mailbox.
//  Revision    : 1.0 - initial release
// ============================================================================
package sndcomm_pkg;

    localparam int STATUS_OFS  = 0;
    localparam int NMI_DIS_OFS = 1;
    localparam int NMI_EN_OFS  = 2;
    localparam int ROUT_OFS    = 3;

    localparam int ST_IN_READY = 0;
    localparam int ST_OUT_PEND = 1;

    typedef enum logic [1:0] {
        PK_SLOT,
        PK_STATUS,
        PK_CTRL,
        PK_NONE
    } page_kind_e;

    function automatic page_kind_e decodePage(input int page, input int numSlots);
        if (page < numSlots)
            return PK_SLOT;
        else if (page == numSlots + STATUS_OFS)
            return PK_STATUS;
        else if (page >= numSlots + NMI_DIS_OFS && page <= numSlots + ROUT_OFS)
            return PK_CTRL;
        return PK_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sndcomm_if.sv
`default_nettype none
// ============================================================================
//  Module      : sndcomm_if
//  Description : One CPU bus port of the mailbox (chip select, strobes,
//                address bit, data in/out and output-enable).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sndcomm_if #(
    parameter int DATA_W = 4
);
    logic              nCS;
    logic              nRD;
    logic              nWR;
    logic              A0;
    logic [DATA_W-1:0] D_I;
    logic [DATA_W-1:0] D_O;
    logic              D_OE;

    modport master (
        output nCS, nRD, nWR, A0, D_I,
        input  D_O, D_OE
    );

    modport slave (
        input  nCS, nRD, nWR, A0, D_I,
        output D_O, D_OE
    );
endinterface
`default_nettype wire

// File: rtl/sndcomm_port.sv
`default_nettype none
// ============================================================================
//  Module      : sndcomm_port
//  Description : Per-CPU access front end: optional input synchroniser
//                (SNDCOMM_SYNC_EN), strobe edge detect, page pointer, decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module sndcomm_port
    import sndcomm_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int NUM_SLOTS = 4,
    parameter int PAGE_W    = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_nCs,
    input  wire logic              i_nRd,
    input  wire logic              i_nWr,
    input  wire logic              i_a0,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_wrCommit,
    output logic                   o_rdCommit,
    output page_kind_e             o_kind,
    output logic [PAGE_W-1:0]      o_page,
    output logic [DATA_W-1:0]      o_wrData
);

    // Sample layout: {nCS, nRD, nWR, A0, data}; idle value keeps strobes high.
    localparam int              IN_W   = DATA_W + 4;
    localparam logic [IN_W-1:0] c_IDLE = {3'b111, {(DATA_W + 1){1'b0}}};

    logic [IN_W-1:0]   w_raw;
    logic [IN_W-1:0]   w_in;
    logic [IN_W-1:0]   r_cur;
    logic [IN_W-1:0]   r_prev;
    logic [PAGE_W-1:0] r_ptr;
    logic              w_wrEdge;
    logic              w_rdEdge;
    logic              w_pageLoad;

    assign w_raw = {i_nCs, i_nRd, i_nWr, i_a0, i_data};

`ifdef SNDCOMM_SYNC_EN
    logic [IN_W-1:0] r_sync1;
    logic [IN_W-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= c_IDLE;
            r_sync2 <= c_IDLE;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_in = r_sync2;
`else
    assign w_in = w_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur  <= c_IDLE;
            r_prev <= c_IDLE;
        end else begin
            r_cur  <= w_in;
            r_prev <= r_cur;
        end
    end

    // Commit on the rising strobe; CS, A0 and data come from the last low sample.
    assign w_wrEdge   = r_cur[IN_W-3] & ~r_prev[IN_W-3] & ~r_prev[IN_W-1];
    assign w_rdEdge   = r_cur[IN_W-2] & ~r_prev[IN_W-2] & ~r_prev[IN_W-1];
    assign o_wrCommit = w_wrEdge & r_prev[DATA_W];
    assign o_rdCommit = w_rdEdge & r_prev[DATA_W];
    assign w_pageLoad = w_wrEdge & ~r_prev[DATA_W];
    assign o_wrData   = r_prev[DATA_W-1:0];
    assign o_kind     = decodePage(int'(r_ptr), NUM_SLOTS);
    assign o_page     = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_pageLoad) begin
            r_ptr <= r_prev[PAGE_W-1:0];
        end else if ((o_wrCommit || o_rdCommit) && o_kind == PK_SLOT) begin
            r_ptr <= (int'(r_ptr) == NUM_SLOTS - 1) ? '0 : r_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sndcomm_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : sndcomm_mailbox
//  Description : Main/sound CPU mailbox with paged slots, status, NMI and
//                sound-CPU reset control. SNDCOMM_SYNC_EN adds input sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module sndcomm_mailbox
    import sndcomm_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int NUM_SLOTS = 4,
    parameter int PAGE_W    = 4
) (
    input  wire logic CLK,
    input  wire logic nIC,
    sndcomm_if.slave  mBus,
    sndcomm_if.slave  sBus,
    output logic      nNMI,
    output logic      nROUT
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic              w_mWr, w_mRd, w_sWr, w_sRd;
    page_kind_e        w_mKind, w_sKind;
    logic [PAGE_W-1:0] w_mPage, w_sPage;
    logic [DATA_W-1:0] w_mData, w_sData;
    logic [DATA_W-1:0] w_mRdData, w_sRdData;
    logic              w_mOe, w_sOe;
    logic              w_mLast, w_sLast;

    logic [DATA_W-1:0] r_m2s [NUM_SLOTS];
    logic [DATA_W-1:0] r_s2m [NUM_SLOTS];
    logic              r_m2sReady;
    logic              r_s2mReady;
    logic              r_nmiEn;
    logic              r_rout;

    sndcomm_port #(.DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .PAGE_W(PAGE_W)) u_mPort (
        .clk(CLK), .rst_n(nIC),
        .i_nCs(mBus.nCS), .i_nRd(mBus.nRD), .i_nWr(mBus.nWR), .i_a0(mBus.A0), .i_data(mBus.D_I),
        .o_wrCommit(w_mWr), .o_rdCommit(w_mRd), .o_kind(w_mKind), .o_page(w_mPage), .o_wrData(w_mData)
    );

    sndcomm_port #(.DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .PAGE_W(PAGE_W)) u_sPort (
        .clk(CLK), .rst_n(nIC),
        .i_nCs(sBus.nCS), .i_nRd(sBus.nRD), .i_nWr(sBus.nWR), .i_a0(sBus.A0), .i_data(sBus.D_I),
        .o_wrCommit(w_sWr), .o_rdCommit(w_sRd), .o_kind(w_sKind), .o_page(w_sPage), .o_wrData(w_sData)
    );

    assign w_mLast = (w_mKind == PK_SLOT) && (int'(w_mPage) == NUM_SLOTS - 1);
    assign w_sLast = (w_sKind == PK_SLOT) && (int'(w_sPage) == NUM_SLOTS - 1);
    assign w_mOe   = ~mBus.nCS & ~mBus.nRD;
    assign w_sOe   = ~sBus.nCS & ~sBus.nRD;

    always_ff @(posedge CLK or negedge nIC) begin
        if (!nIC) begin
            r_m2s      <= '{default: '0};
            r_s2m      <= '{default: '0};
            r_m2sReady <= 1'b0;
            r_s2mReady <= 1'b0;
            r_nmiEn    <= 1'b0;
            r_rout     <= 1'b1;
        end else begin
            if (w_mWr && w_mKind == PK_SLOT)
                r_m2s[w_mPage[SLOT_W-1:0]] <= w_mData;
            if (w_sWr && w_sKind == PK_SLOT)
                r_s2m[w_sPage[SLOT_W-1:0]] <= w_sData;

            // Set has priority over a same-cycle clear from the receiving side.
            if (w_mWr && w_mLast)
                r_m2sReady <= 1'b1;
            else if (w_sRd && w_sLast)
                r_m2sReady <= 1'b0;

            if (w_sWr && w_sLast)
                r_s2mReady <= 1'b1;
            else if (w_mRd && w_mLast)
                r_s2mReady <= 1'b0;

            if (w_sWr && int'(w_sPage) == NUM_SLOTS + NMI_DIS_OFS)
                r_nmiEn <= 1'b0;
            else if (w_sWr && int'(w_sPage) == NUM_SLOTS + NMI_EN_OFS)
                r_nmiEn <= 1'b1;

            if (w_mWr && int'(w_mPage) == NUM_SLOTS + ROUT_OFS)
                r_rout <= w_mData[0];
        end
    end

    // Read data follows the live pointer and A0; nothing changes until commit.
    always_comb begin
        w_mRdData = '0;
        if (w_mOe) begin
            if (!mBus.A0) begin
                w_mRdData[PAGE_W-1:0] = w_mPage;
            end else begin
                case (w_mKind)
                    PK_SLOT: w_mRdData = r_s2m[w_mPage[SLOT_W-1:0]];
                    PK_STATUS: begin
                        w_mRdData[ST_IN_READY] = r_s2mReady;
                        w_mRdData[ST_OUT_PEND] = r_m2sReady;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_sRdData = '0;
        if (w_sOe) begin
            if (!sBus.A0) begin
                w_sRdData[PAGE_W-1:0] = w_sPage;
            end else begin
                case (w_sKind)
                    PK_SLOT: w_sRdData = r_m2s[w_sPage[SLOT_W-1:0]];
                    PK_STATUS: begin
                        w_sRdData[ST_IN_READY] = r_m2sReady;
                        w_sRdData[ST_OUT_PEND] = r_s2mReady;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mBus.D_O  = w_mRdData;
    assign mBus.D_OE = w_mOe;
    assign sBus.D_O  = w_sRdData;
    assign sBus.D_OE = w_sOe;
    assign nNMI      = ~(r_nmiEn & r_m2sReady);
    assign nROUT     = ~r_rout;

endmodule
`default_nettype wire

// File: tb/tb_sndcomm_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sndcomm_mailbox
//  Description : Directed bench for sndcomm_mailbox; read data is checked by
//                per-port monitors against queued expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sndcomm_mailbox;

`ifdef SNDCOMM_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic nIC;
    logic nNMI;
    logic nROUT;
    int   tests;
    int   fails;

    logic [3:0] mQ[$];
    logic [3:0] sQ[$];
    logic       mOePrev;
    logic       sOePrev;

    sndcomm_if #(.DATA_W(4)) mb ();
    sndcomm_if #(.DATA_W(4)) sb ();

    sndcomm_mailbox #(.DATA_W(4), .NUM_SLOTS(4), .PAGE_W(4)) dut (
        .CLK(clk), .nIC(nIC), .mBus(mb), .sBus(sb), .nNMI(nNMI), .nROUT(nROUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: one expected value per read, popped when OE first appears.
    always @(negedge clk) begin
        if (mb.D_OE && !mOePrev) begin
            if (mQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL mrd_unexpected: got 0x%0h, expected no read", mb.D_O);
            end else begin
                chk("mrd", {28'd0, mb.D_O}, {28'd0, mQ.pop_front()});
            end
        end
        if (sb.D_OE && !sOePrev) begin
            if (sQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL srd_unexpected: got 0x%0h, expected no read", sb.D_O);
            end else begin
                chk("srd", {28'd0, sb.D_O}, {28'd0, sQ.pop_front()});
            end
        end
        mOePrev = mb.D_OE;
        sOePrev = sb.D_OE;
    end

    // Assert CS + strobe, hold two cycles, then raise the strobe (CS stays low).
    task automatic strobe(input bit side, input bit wr, input bit a0, input logic [3:0] d);
        @(posedge clk); #1;
        if (!side) begin
            mb.nCS = 1'b0; mb.A0 = a0; mb.D_I = d;
            if (wr) mb.nWR = 1'b0; else mb.nRD = 1'b0;
        end else begin
            sb.nCS = 1'b0; sb.A0 = a0; sb.D_I = d;
            if (wr) sb.nWR = 1'b0; else sb.nRD = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        if (!side) begin mb.nWR = 1'b1; mb.nRD = 1'b1; end
        else       begin sb.nWR = 1'b1; sb.nRD = 1'b1; end
    endtask

    task automatic access(input bit side, input bit wr, input bit a0, input logic [3:0] d);
        strobe(side, wr, a0, d);
        repeat (LAT + 1) @(posedge clk);
        #1;
        if (!side) mb.nCS = 1'b1; else sb.nCS = 1'b1;
    endtask

    task automatic wrM(input bit a0, input logic [3:0] d); access(1'b0, 1'b1, a0, d); endtask
    task automatic wrS(input bit a0, input logic [3:0] d); access(1'b1, 1'b1, a0, d); endtask
    task automatic rdM(input logic [3:0] exp); mQ.push_back(exp); access(1'b0, 1'b0, 1'b1, 4'd0); endtask
    task automatic rdS(input logic [3:0] exp); sQ.push_back(exp); access(1'b1, 1'b0, 1'b1, 4'd0); endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tests = 0; fails = 0;
        mOePrev = 1'b0; sOePrev = 1'b0;
        mb.nCS = 1'b1; mb.nRD = 1'b1; mb.nWR = 1'b1; mb.A0 = 1'b0; mb.D_I = 4'd0;
        sb.nCS = 1'b1; sb.nRD = 1'b1; sb.nWR = 1'b1; sb.A0 = 1'b0; sb.D_I = 4'd0;
        nIC = 1'b0;
        repeat (3) @(posedge clk);
        #1 nIC = 1'b1;
        @(posedge clk); #1;

        // 1: reset state
        chk("rst_nNMI",  nNMI,     1);
        chk("rst_nROUT", nROUT,    0);
        chk("rst_MD_OE", mb.D_OE,  0);
        chk("rst_SD_OE", sb.D_OE,  0);
        chk("rst_MD_O",  mb.D_O,   0);
        chk("rst_SD_O",  sb.D_O,   0);
        wrS(1'b0, 4'd4); rdS(4'h0);

        // 2: master fills slots 0..3, slave drains them
        wrM(1'b0, 4'd0);
        wrM(1'b1, 4'd1); wrM(1'b1, 4'd2); wrM(1'b1, 4'd3); wrM(1'b1, 4'd4);
        wrS(1'b0, 4'd4); rdS(4'h1);
        wrS(1'b0, 4'd0);
        rdS(4'd1); rdS(4'd2); rdS(4'd3); rdS(4'd4);
        wrS(1'b0, 4'd4); rdS(4'h0);
        wrM(1'b1, 4'd9);                       // master pointer wrapped to slot 0
        wrS(1'b0, 4'd0); rdS(4'd9);

        // 3: NMI enable and timing
        wrS(1'b0, 4'd6); wrS(1'b1, 4'd0);
        chk("nmi_en_no_ready", nNMI, 1);
        wrM(1'b0, 4'd3);
        strobe(1'b0, 1'b1, 1'b1, 4'd7);
        repeat (LAT) @(posedge clk);
        #1 chk("nmi_not_early", nNMI, 1);
        @(posedge clk);
        #1 chk("nmi_set", nNMI, 0);
        mb.nCS = 1'b1;
        wrS(1'b0, 4'd3); rdS(4'd7);
        chk("nmi_clr", nNMI, 1);

        // 4: sound-CPU reset control
        wrM(1'b0, 4'd7); wrM(1'b1, 4'd0);
        chk("rout_w0", nROUT, 1);
        wrM(1'b1, 4'd1);
        chk("rout_w1", nROUT, 0);
        wrS(1'b0, 4'd7); wrS(1'b1, 4'd0);
        chk("rout_slave", nROUT, 0);
        wrS(1'b0, 4'd5); wrS(1'b1, 4'd0);
        wrM(1'b0, 4'd3); wrM(1'b1, 4'd2);
        chk("nmi_dis", nNMI, 1);

        // 5: simultaneous set and clear of m2s ready
        wrM(1'b0, 4'd3); wrS(1'b0, 4'd3);
        fork
            wrM(1'b1, 4'd6);
            rdS(4'd2);
        join
        wrS(1'b0, 4'd4); rdS(4'h1);
        wrS(1'b0, 4'd3); wrS(1'b1, 4'hA);
        wrS(1'b0, 4'd4); rdS(4'h3);
        wrM(1'b0, 4'd3); rdM(4'hA);
        wrM(1'b0, 4'd4); rdM(4'h2);

        // 6: reset in the middle of a held write
        wrM(1'b0, 4'd7); wrM(1'b1, 4'd0);
        chk("rout_pre_rst", nROUT, 1);
        @(posedge clk); #1;
        mb.nCS = 1'b0; mb.A0 = 1'b1; mb.D_I = 4'd5; mb.nWR = 1'b0;
        repeat (2) @(posedge clk);
        #3 nIC = 1'b0;
        #1 chk("rout_in_rst", nROUT, 0);
        chk("nmi_in_rst", nNMI, 1);
        @(posedge clk);
        #1 nIC = 1'b1;
        repeat (4) @(posedge clk);
        wrS(1'b0, 4'd4); rdS(4'h0);
        wrS(1'b0, 4'd0);
        sQ.push_back(4'd0);
        @(posedge clk); #1;
        sb.nCS = 1'b0; sb.A0 = 1'b1; sb.nRD = 1'b0;
        @(posedge clk); #1;
        chk("slot0_after_rst", sb.D_O, 0);
        mb.nWR = 1'b1;
        repeat (LAT) @(posedge clk);
        #1 chk("held_wr_not_early", sb.D_O, 0);
        @(posedge clk);
        #1 chk("held_wr_commit", sb.D_O, 5);
        mb.nCS = 1'b1;
        sb.nRD = 1'b1;
        repeat (LAT + 1) @(posedge clk);
        #1 sb.nCS = 1'b1;

        repeat (4) @(posedge clk);
        chk("mq_drained", mQ.size(), 0);
        chk("sq_drained", sQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
